// File: rtl/aes_ahb_pkg.sv
// Shared AHB-Lite encodings, job/transfer state types and the decode of the
// fixed 14-op AES register sequence.
package aes_ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_BUS     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   localparam logic [3:0] OP_CTRL = 4'd8;
   localparam logic [3:0] OP_POLL = 4'd9;
   localparam logic [3:0] OP_LAST = 4'd13;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} job_st_t;
   typedef enum logic [1:0] {PH_IDLE, PH_ADDR, PH_DATA} xfer_ph_t;
   typedef enum logic [1:0] {WS_NONE, WS_KEY, WS_PT, WS_START} wsel_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      wsel_t       wsel;
      logic [1:0]  word;
   } op_t;

   function automatic logic [31:0] get_word(input logic [127:0] d, input logic [1:0] i);
      logic [31:0] w;
      case (i)
         2'd0:    w = d[127:96];
         2'd1:    w = d[95:64];
         2'd2:    w = d[63:32];
         default: w = d[31:0];
      endcase
      return w;
   endfunction

   function automatic op_t op_decode(input logic [3:0] op, input logic [31:0] key_base,
                                     input logic [31:0] din_base, input logic [31:0] ctrl_addr,
                                     input logic [31:0] stat_addr, input logic [31:0] dout_base);
      op_t d;
      d.write = 1'b0;
      d.wsel  = WS_NONE;
      d.word  = op[1:0];
      d.addr  = stat_addr;
      if (op < 4'd4) begin
         d.write = 1'b1;
         d.wsel  = WS_KEY;
         d.addr  = key_base + {28'd0, op[1:0], 2'b00};
      end else if (op < 4'd8) begin
         d.write = 1'b1;
         d.wsel  = WS_PT;
         d.addr  = din_base + {28'd0, op[1:0], 2'b00};
      end else if (op == OP_CTRL) begin
         d.write = 1'b1;
         d.wsel  = WS_START;
         d.addr  = ctrl_addr;
      end else if (op != OP_POLL) begin
         d.word = op[1:0] - 2'd2;
         d.addr = dout_base + {28'd0, d.word, 2'b00};
      end
      return d;
   endfunction
endpackage

// File: rtl/ahb_lite_xfer.sv
// Single-transfer AHB-Lite engine: one NONSEQ address cycle, then a data phase
// held until HREADY. A new request may be issued on the completing data cycle.
//   phase   | meaning
//   PH_IDLE | no transfer in flight
//   PH_ADDR | address phase on the bus (HTRANS = NONSEQ)
//   PH_DATA | data phase, waiting for HREADY
module ahb_lite_xfer
   import aes_ahb_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);
   xfer_ph_t ph;
   logic     issue;

   // An error completes only with HREADY high, so the first error cycle just waits.
   assign done   = (ph == PH_DATA) && HREADY;
   assign err    = done && HRESP;
   assign rdata  = HRDATA;
   assign issue  = req && ((ph == PH_IDLE) || (done && !HRESP));
   assign HSIZE  = HSIZE_WORD;
   assign HBURST = HBURST_SINGLE;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ph     <= PH_IDLE;
         HADDR  <= '0;
         HTRANS <= HTRANS_IDLE;
         HWRITE <= 1'b0;
         HWDATA <= '0;
      end else if (issue) begin
         ph     <= PH_ADDR;
         HADDR  <= addr;
         HWRITE <= write;
         HWDATA <= wdata;
         HTRANS <= HTRANS_NONSEQ;
      end else if (ph == PH_ADDR) begin
         ph     <= PH_DATA;
         HTRANS <= HTRANS_IDLE;
      end else if (done) begin
         ph <= PH_IDLE;
      end
   end
endmodule

// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator running one AES-128 job as a fixed list of single transfers.
//   state   | meaning
//   ST_IDLE | job_ready high, waiting for job_valid
//   ST_RUN  | sequencing ops 0..13 through the transfer engine
//   ST_DONE | one-cycle res_valid pulse with res_ct / res_err
module aes_ahb_master
   import aes_ahb_pkg::*;
#(
   parameter logic [31:0] KEY_BASE  = 32'h00,
   parameter logic [31:0] DIN_BASE  = 32'h10,
   parameter logic [31:0] CTRL_ADDR = 32'h20,
   parameter logic [31:0] STAT_ADDR = 32'h24,
   parameter logic [31:0] DOUT_BASE = 32'h30,
   parameter int          POLL_MAX  = 64
) (
   input  logic         HCLK,
   input  logic         HRESETn,
   input  logic         job_valid,
   output logic         job_ready,
   input  logic [127:0] job_key,
   input  logic [127:0] job_pt,
   output logic         res_valid,
   output logic [127:0] res_ct,
   output logic [1:0]   res_err,
   output logic [31:0]  HADDR,
   output logic [1:0]   HTRANS,
   output logic         HWRITE,
   output logic [2:0]   HSIZE,
   output logic [2:0]   HBURST,
   output logic [31:0]  HWDATA,
   input  logic [31:0]  HRDATA,
   input  logic         HREADY,
   input  logic         HRESP
);
   localparam int PW = $clog2(POLL_MAX + 1);
   localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_MAX);

   job_st_t        st;
   logic [3:0]     op_idx;
   logic [3:0]     next_op;
   logic [PW-1:0]  poll_left;
   logic [127:0]   key_q;
   logic [127:0]   pt_q;
   logic           accept;
   logic           req;
   logic           last_op;
   logic           timeout;
   logic           xfer_done;
   logic           xfer_err;
   logic [31:0]    rdata;
   logic [31:0]    wdata;
   op_t            nxt;

   assign accept = job_valid && job_ready;
   assign nxt    = op_decode(next_op, KEY_BASE, DIN_BASE, CTRL_ADDR, STAT_ADDR, DOUT_BASE);

   always_comb begin
      last_op = (op_idx == OP_LAST);
      timeout = (op_idx == OP_POLL) && !rdata[0] && (poll_left <= PW'(1));
      if (st == ST_IDLE)
         next_op = '0;
      else if ((op_idx == OP_POLL) && !rdata[0])
         next_op = OP_POLL;
      else
         next_op = op_idx + 4'd1;
   end

   // Op 0 is issued on the accept edge, before key_q holds the new key.
   always_comb begin
      case (nxt.wsel)
         WS_KEY:   wdata = get_word(accept ? job_key : key_q, nxt.word);
         WS_PT:    wdata = get_word(pt_q, nxt.word);
         WS_START: wdata = 32'h1;
         default:  wdata = '0;
      endcase
   end

   assign req = accept || ((st == ST_RUN) && xfer_done && !xfer_err && !last_op && !timeout);

   ahb_lite_xfer u_xfer (
      .HCLK   (HCLK),
      .HRESETn(HRESETn),
      .req    (req),
      .addr   (nxt.addr),
      .write  (nxt.write),
      .wdata  (wdata),
      .done   (xfer_done),
      .err    (xfer_err),
      .rdata  (rdata),
      .HADDR  (HADDR),
      .HTRANS (HTRANS),
      .HWRITE (HWRITE),
      .HSIZE  (HSIZE),
      .HBURST (HBURST),
      .HWDATA (HWDATA),
      .HRDATA (HRDATA),
      .HREADY (HREADY),
      .HRESP  (HRESP)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         st        <= ST_IDLE;
         job_ready <= 1'b0;
         res_valid <= 1'b0;
         res_ct    <= '0;
         res_err   <= ERR_OK;
         op_idx    <= '0;
         poll_left <= '0;
         key_q     <= '0;
         pt_q      <= '0;
      end else begin
         res_valid <= 1'b0;
         if (req)
            op_idx <= next_op;
         case (st)
            ST_IDLE: begin
               job_ready <= 1'b1;
               if (accept) begin
                  st        <= ST_RUN;
                  job_ready <= 1'b0;
                  key_q     <= job_key;
                  pt_q      <= job_pt;
                  res_ct    <= '0;
                  res_err   <= ERR_OK;
               end
            end
            ST_RUN: begin
               if (xfer_done && xfer_err) begin
                  st        <= ST_DONE;
                  res_valid <= 1'b1;
                  res_err   <= ERR_BUS;
               end else if (xfer_done) begin
                  if (op_idx == OP_CTRL)
                     poll_left <= POLL_LOAD;
                  if ((op_idx == OP_POLL) && (poll_left != '0))
                     poll_left <= poll_left - PW'(1);
                  case (op_idx)
                     4'd10:   res_ct[127:96] <= rdata;
                     4'd11:   res_ct[95:64]  <= rdata;
                     4'd12:   res_ct[63:32]  <= rdata;
                     4'd13:   res_ct[31:0]   <= rdata;
                     default: ;
                  endcase
                  if (last_op || timeout) begin
                     st        <= ST_DONE;
                     res_valid <= 1'b1;
                     res_err   <= last_op ? ERR_OK : ERR_TIMEOUT;
                  end
               end
            end
            default: begin
               st        <= ST_IDLE;
               job_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_ahb_master.sv
// Directed bench for aes_ahb_master with a negedge-driven AES slave model.
module tb_aes_ahb_master;
   import aes_ahb_pkg::*;

   localparam int POLL_MAX = 4;

   logic         HCLK = 1'b0;
   logic         HRESETn = 1'b0;
   logic         job_valid = 1'b0;
   logic         job_ready;
   logic [127:0] job_key = '0;
   logic [127:0] job_pt = '0;
   logic         res_valid;
   logic [127:0] res_ct;
   logic [1:0]   res_err;
   logic [31:0]  HADDR;
   logic [1:0]   HTRANS;
   logic         HWRITE;
   logic [2:0]   HSIZE;
   logic [2:0]   HBURST;
   logic [31:0]  HWDATA;
   logic [31:0]  HRDATA = '0;
   logic         HREADY = 1'b1;
   logic         HRESP = 1'b0;

   always #5 HCLK = ~HCLK;

   aes_ahb_master #(.POLL_MAX(POLL_MAX)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_pt(job_pt),
      .res_valid(res_valid), .res_ct(res_ct), .res_err(res_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // slave model state
   logic [127:0] ct_model = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   int           done_after, wait_op, wait_n, err_op;
   int           xfer_n, stat_reads, wr_n, hold_cycles, hold_bad, proto_bad;
   logic [31:0]  hold_exp;
   logic [31:0]  wr_addr [16];
   logic [31:0]  wr_data [16];
   logic         in_dp = 1'b0;
   logic         dp_write, dp_err, done_bit;
   logic [31:0]  dp_addr;
   int           dp_idx, wait_left;

   task automatic slave_setup(input int da, input int wop, input int wn, input int eop);
      done_after = da; wait_op = wop; wait_n = wn; err_op = eop;
      xfer_n = 0; stat_reads = 0; wr_n = 0; hold_cycles = 0; hold_bad = 0; proto_bad = 0;
   endtask

   function automatic logic [31:0] ct_word(input logic [31:0] a);
      case (a)
         32'h30:  return ct_model[127:96];
         32'h34:  return ct_model[95:64];
         32'h38:  return ct_model[63:32];
         32'h3c:  return ct_model[31:0];
         default: return 32'hbad0bad0;
      endcase
   endfunction

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         in_dp = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      end else begin
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
         if (in_dp) begin
            if (HTRANS == HTRANS_NONSEQ) proto_bad++;
            if (dp_idx == wait_op && dp_write) begin
               hold_cycles++;
               if (HWDATA !== hold_exp) hold_bad++;
            end
            HRESP = dp_err;
            if (wait_left > 0) begin
               HREADY = 1'b0;
               wait_left--;
            end else begin
               in_dp = 1'b0;
               if (!dp_err) begin
                  if (dp_write) begin
                     if (wr_n < 16) begin
                        wr_addr[wr_n] = dp_addr;
                        wr_data[wr_n] = HWDATA;
                     end
                     wr_n++;
                  end else if (dp_addr == 32'h24) begin
                     stat_reads++;
                     done_bit = (done_after > 0) && (stat_reads >= done_after);
                     HRDATA = {31'd0, done_bit};
                  end else begin
                     HRDATA = ct_word(dp_addr);
                  end
               end
            end
         end else if (HTRANS == HTRANS_NONSEQ) begin
            if (HSIZE !== HSIZE_WORD || HBURST !== HBURST_SINGLE) proto_bad++;
            in_dp = 1'b1;
            dp_addr = HADDR; dp_write = HWRITE; dp_idx = xfer_n;
            dp_err = (xfer_n == err_op);
            wait_left = dp_err ? 1 : ((xfer_n == wait_op) ? wait_n : 0);
            xfer_n++;
         end
      end
   end

   logic [127:0] got_ct;
   logic [1:0]   got_err;

   // Accept edge is cycle 0; the first negedge after it samples cycle 1.
   task automatic run_job(input logic [127:0] k, input logic [127:0] p, output int lat,
                          output bit ready_bad, output bit ready_after, output bit pulse_after);
      @(negedge HCLK);
      job_key = k; job_pt = p; job_valid = 1'b1;
      @(posedge HCLK);
      #1 job_valid = 1'b0;
      lat = 0; ready_bad = 1'b0;
      while (lat < 200) begin
         @(negedge HCLK);
         lat++;
         if (job_ready) ready_bad = 1'b1;
         if (res_valid) break;
      end
      check_eq("res_valid_seen", res_valid, 1'b1);
      got_ct = res_ct; got_err = res_err;
      @(negedge HCLK);
      ready_after = job_ready; pulse_after = res_valid;
   endtask

   logic [31:0] exp_wa [9] = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c, 32'h20};
   logic [31:0] exp_wd [9] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                               32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 32'h00000001};

   initial begin
      int lat;
      bit rb, ra, pa;
      slave_setup(1, -1, 0, -1);
      repeat (2) @(negedge HCLK);
      check_eq("rst_job_ready", job_ready, 1'b0);
      check_eq("rst_res_valid", res_valid, 1'b0);
      check_eq("rst_res_ct", res_ct, 128'h0);
      check_eq("rst_res_err", res_err, 2'b00);
      check_eq("rst_htrans", HTRANS, 2'b00);
      check_eq("rst_haddr", HADDR, 32'h0);
      check_eq("rst_hwrite", HWRITE, 1'b0);
      check_eq("rst_hwdata", HWDATA, 32'h0);
      check_eq("rst_hsize", HSIZE, 3'b010);
      check_eq("rst_hburst", HBURST, 3'b000);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("ready_after_rst", job_ready, 1'b1);

      // FIPS-197 vector, done on third poll
      slave_setup(3, -1, 0, -1);
      run_job(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
              lat, rb, ra, pa);
      check_eq("fips_ct", got_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_eq("fips_err", got_err, 2'b00);
      check_eq("fips_latency", lat, 33);
      check_eq("fips_stat_reads", stat_reads, 3);
      check_eq("fips_write_count", wr_n, 9);
      for (int i = 0; i < 9; i++) begin
         check_eq($sformatf("fips_waddr%0d", i), wr_addr[i], exp_wa[i]);
         check_eq($sformatf("fips_wdata%0d", i), wr_data[i], exp_wd[i]);
      end
      check_eq("fips_proto", proto_bad, 0);

      // zero-wait, done on first poll: exact latency and job_ready window
      slave_setup(1, -1, 0, -1);
      run_job(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
              lat, rb, ra, pa);
      check_eq("zw_latency", lat, 29);
      check_eq("zw_ready_low", rb, 1'b0);
      check_eq("zw_ready_after", ra, 1'b1);
      check_eq("zw_pulse_width", pa, 1'b0);
      check_eq("zw_ct", got_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_eq("zw_err", got_err, 2'b00);

      // two wait states on op 5: HWDATA held for 3 data cycles
      slave_setup(1, 5, 2, -1);
      hold_exp = 32'hcafef00d;
      run_job(128'h0, 128'hdeadbeefcafef00d0123456789abcdef, lat, rb, ra, pa);
      check_eq("ws_latency", lat, 31);
      check_eq("ws_hold_cycles", hold_cycles, 3);
      check_eq("ws_hold_bad", hold_bad, 0);
      check_eq("ws_wdata5", wr_data[5], 32'hcafef00d);
      check_eq("ws_err", got_err, 2'b00);

      // two-cycle error response on op 2
      slave_setup(1, -1, 0, 2);
      run_job(128'h1, 128'h2, lat, rb, ra, pa);
      check_eq("be_latency", lat, 8);
      check_eq("be_err", got_err, 2'b01);
      check_eq("be_ct", got_ct, 128'h0);
      repeat (5) @(negedge HCLK);
      check_eq("be_xfer_count", xfer_n, 3);
      check_eq("be_htrans_idle", HTRANS, 2'b00);

      // done never set: exactly POLL_MAX status reads
      slave_setup(0, -1, 0, -1);
      run_job(128'h3, 128'h4, lat, rb, ra, pa);
      check_eq("to_latency", lat, 27);
      check_eq("to_stat_reads", stat_reads, 4);
      check_eq("to_err", got_err, 2'b10);
      check_eq("to_ct", got_ct, 128'h0);

      // done on the last allowed poll still succeeds
      slave_setup(4, -1, 0, -1);
      run_job(128'h5, 128'h6, lat, rb, ra, pa);
      check_eq("lastpoll_latency", lat, 35);
      check_eq("lastpoll_err", got_err, 2'b00);
      check_eq("lastpoll_ct", got_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

      // reset during op 10 data phase (cycle 22)
      slave_setup(1, -1, 0, -1);
      @(negedge HCLK);
      job_key = 128'h7; job_pt = 128'h8; job_valid = 1'b1;
      @(posedge HCLK);
      #1 job_valid = 1'b0;
      repeat (22) @(negedge HCLK);
      check_eq("mr_xfer_count", xfer_n, 11);
      check_eq("mr_haddr_before", HADDR, 32'h30);
      #1 HRESETn = 1'b0;
      #1;
      check_eq("mr_job_ready", job_ready, 1'b0);
      check_eq("mr_res_valid", res_valid, 1'b0);
      check_eq("mr_res_ct", res_ct, 128'h0);
      check_eq("mr_res_err", res_err, 2'b00);
      check_eq("mr_htrans", HTRANS, 2'b00);
      check_eq("mr_haddr", HADDR, 32'h0);
      check_eq("mr_hwdata", HWDATA, 32'h0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      check_eq("mr_ready_after", job_ready, 1'b1);
      slave_setup(1, -1, 0, -1);
      run_job(128'h9, 128'ha, lat, rb, ra, pa);
      check_eq("mr_rerun_latency", lat, 29);
      check_eq("mr_rerun_ct", got_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_eq("mr_rerun_err", got_err, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
